// File: rtl/spi_addr_sequencer_pkg.sv
// Shared types for the SPI address sequencer.
// Holds the mode, state and direction encodings used by the top module.
package spi_addr_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'd0,
      MODE_ONESHOT  = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/spi_addr_sequencer_if.sv
// Bus between the serial clock generator / controller and the sequencer.
// Inputs: tick, run enable, start and window config; outputs: address, next, busy, done.
interface spi_addr_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int BEAT_WIDTH = 4
);
   logic                  sclkPosEdge;
   logic                  pcEn;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] end_addr;
   logic [BEAT_WIDTH-1:0] beats_per_word;
   logic [1:0]            mode;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic                  next;
   logic                  busy;
   logic                  done;

   modport master (
      output sclkPosEdge, pcEn, start,
      output base_addr, end_addr,
      output beats_per_word, mode,
      input  memAddr, next, busy, done
   );

   modport slave (
      input  sclkPosEdge, pcEn, start,
      input  base_addr, end_addr,
      input  beats_per_word, mode,
      output memAddr, next, busy, done
   );
endinterface

// File: rtl/spi_addr_sequencer_beat_counter.sv
// Counts qualified ticks against the latched beats-per-word value.
// Ports: clk_i, reset_i, clr_i, tick_i, beats_i in; wordDone_o (combinational) out.
module spi_addr_sequencer_beat_counter #(
   parameter int BEAT_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clr_i,
   input  logic                  tick_i,
   input  logic [BEAT_WIDTH-1:0] beats_i,
   output logic                  wordDone_o
);

   logic [BEAT_WIDTH-1:0] count_q, count_d;

   assign wordDone_o = tick_i &&
      (count_q == beats_i - BEAT_WIDTH'(1));

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (tick_i)
         count_d = wordDone_o ? '0 : count_q + BEAT_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/spi_addr_sequencer.sv
// Steps memAddr through [base,end] every beats qualified ticks (wrap/one-shot/ping-pong).
// Ports: clk, reset (sync, active high); bus (slave modport) carries all control and outputs.
module spi_addr_sequencer
   import spi_addr_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int BEAT_WIDTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   spi_addr_sequencer_if.slave bus
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   state_e                state_q;
   dir_e                  dir_q;
   addr_t                 addr_q;
   logic                  next_q;
   logic                  busy_q;
   logic                  done_q;
   addr_t                 base_q;
   addr_t                 end_q;
   logic [BEAT_WIDTH-1:0] beats_q;
   mode_e                 mode_q;

   addr_t adv_addr_d;
   dir_e  adv_dir_d;
   logic  adv_fin_d;
   logic  tick;
   logic  wordDone;
   logic  is_os;
   logic  is_pp;

   // A tick coincident with start belongs to the old sequence and is dropped.
   assign tick = (state_q == ST_RUN) && bus.pcEn &&
                 bus.sclkPosEdge && !bus.start;

   spi_addr_sequencer_beat_counter #(
      .BEAT_WIDTH(BEAT_WIDTH)
   ) u_beat (
      .clk_i      (clk),
      .reset_i    (reset),
      .clr_i      (bus.start),
      .tick_i     (tick),
      .beats_i    (beats_q),
      .wordDone_o (wordDone)
   );

   // Ping-pong needs an ordered window; otherwise fall back to wrap.
   assign is_os = (mode_q == MODE_ONESHOT);
   assign is_pp = (mode_q == MODE_PINGPONG) && (base_q <= end_q);

   always_comb begin
      adv_addr_d = addr_q + addr_t'(1);
      adv_dir_d  = dir_q;
      adv_fin_d  = 1'b0;
      unique case (1'b1)
         is_os: begin
            if (addr_q == end_q) begin
               adv_addr_d = addr_q;
               adv_fin_d  = 1'b1;
            end
         end
         is_pp: begin
            if (base_q == end_q) begin
               adv_addr_d = addr_q;
            end else if (dir_q == DIR_UP) begin
               if (addr_q == end_q) begin
                  adv_dir_d  = DIR_DOWN;
                  adv_addr_d = addr_q - addr_t'(1);
               end
            end else if (addr_q == base_q) begin
               adv_dir_d = DIR_UP;
            end else begin
               adv_addr_d = addr_q - addr_t'(1);
            end
         end
         default: begin
            if (addr_q == end_q)
               adv_addr_d = base_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         addr_q  <= '0;
         next_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         base_q  <= '0;
         end_q   <= '0;
         beats_q <= '0;
         mode_q  <= MODE_WRAP;
      end else begin
         next_q <= 1'b0;
         done_q <= 1'b0;
         if (bus.start) begin
            base_q  <= bus.base_addr;
            end_q   <= bus.end_addr;
            beats_q <= (bus.beats_per_word == '0) ?
                       BEAT_WIDTH'(1) : bus.beats_per_word;
            mode_q  <= mode_e'(bus.mode);
            addr_q  <= bus.base_addr;
            dir_q   <= DIR_UP;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
         end else if (wordDone) begin
            next_q <= 1'b1;
            addr_q <= adv_addr_d;
            dir_q  <= adv_dir_d;
            if (adv_fin_d) begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   assign bus.memAddr = addr_q;
   assign bus.next    = next_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: doc/spi_addr_sequencer.md
Name: spi_addr_sequencer

Overview:
Parametrised successor to the SPI-fed program counter. It steps a memory address through a programmable window [base_addr, end_addr]. The address advances once every beats_per_word qualified serial-clock edges, and each advance emits a one-cycle next pulse. Three modes are supported: wrap, one-shot and ping-pong. It sits between the serial clock generator and the sample memory feeding the SPI shifter.

Parameters:
ADDR_WIDTH, 16, width of memAddr, base_addr and end_addr
BEAT_WIDTH, 4, width of the beats_per_word field and of the internal beat counter

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
sclkPosEdge  in  1  one-clk strobe marking a serial-clock rising edge (the "tick")
pcEn  in  1  run enable; when low, ticks are ignored and all state holds
start  in  1  one-clk pulse; latches the configuration and (re)starts the sequence
base_addr  in  ADDR_WIDTH  first address of the window
end_addr  in  ADDR_WIDTH  last address of the window
beats_per_word  in  BEAT_WIDTH  ticks per address; a value of 0 is treated as 1
mode  in  2  0 = wrap, 1 = one-shot, 2 = ping-pong, 3 = reserved (behaves as wrap)
memAddr  out  ADDR_WIDTH  current address, registered
next  out  1  one-clk pulse, registered, on each address advance
busy  out  1  high while in RUN
done  out  1  one-clk pulse when a one-shot sequence completes

Behaviour:
- Reset values: memAddr=0, next=0, done=0, busy=0, state=IDLE, beat count=0, direction=up, latched configuration=0.
- Reset has priority over everything else, including mid-sequence; all reset values appear in the cycle after reset is sampled.
- States:
  - IDLE: ignores ticks.
  - RUN: counts ticks and advances the address.
- start (any state):
  - Latches base, end, beats (0 becomes 1) and mode.
  - Sets memAddr<=base, count<=0, direction<=up, state<=RUN, busy<=1.
  - A tick arriving in the same cycle as start is ignored.
- Qualified tick = RUN && pcEn && sclkPosEdge.
  - If count < beats-1: count increments.
  - Otherwise: count<=0, next<=1 and the address advances, all in the same registered update. next is high for exactly one clk cycle.
- Address advance, wrap mode:
  - If memAddr==end: memAddr<=base.
  - Otherwise: memAddr<=memAddr+1, modulo 2^ADDR_WIDTH.
  - If end<base, the address runs through the top of the space and wraps to 0 before reaching end.
- Address advance, one-shot mode:
  - If memAddr==end: memAddr holds end, done<=1 (one pulse), state<=IDLE, busy<=0. next still pulses on this final advance.
  - Otherwise: increment as in wrap mode.
- Address advance, ping-pong mode (requires base<=end; if end<base, the block behaves as wrap):
  - Moving up and memAddr==end: direction<=down, memAddr<=end-1.
  - Moving down and memAddr==base: direction<=up, memAddr<=base+1.
  - Otherwise: memAddr steps by ±1 according to direction.
  - If base==end: memAddr stays at base and next still pulses.
- pcEn low: count, address, direction and state all freeze. Counting resumes exactly where it stopped; no tick is lost or double-counted.
- Configuration inputs are only sampled on start; changing them during RUN has no effect.
- Latency: memAddr and next both update in the clk cycle after the qualifying tick is sampled.

Decomposition:
- Shared package holds:
  - mode constants: MODE_WRAP=2'd0, MODE_ONESHOT=2'd1, MODE_PINGPONG=2'd2
  - state encoding: ST_IDLE, ST_RUN
  - direction constants: DIR_UP, DIR_DOWN
- One natural sub-module, beat_counter:
  - Counts qualified ticks against the latched beats value.
  - Outputs a combinational wordDone when count==beats-1 and a tick is present.
  - Clears on start or reset.
- The address/mode logic and FSM live in the top module.

Test Plan:
1. Reset then start with base=0, end=3, beats=8, wrap, ticks every 4 clk, pcEn=1 -> memAddr goes 0,1,2,3,0,1; next pulses every 8 ticks; done never asserts; busy=1.
2. One-shot with base=10, end=12, beats=2 -> memAddr 10,11,12; at the advance from 12, next and done pulse together; busy falls to 0 and memAddr holds 12; further ticks change nothing.
3. Ping-pong with base=5, end=7, beats=1 -> memAddr 5,6,7,6,5,6,7; next pulses on every tick.
4. pcEn dropped for 500 ns after 5 of 8 ticks (wrap, beats=8) -> no advance while low; next pulses on the 3rd tick after pcEn returns.
5. Assert reset mid-RUN at memAddr=0x0042 -> the next cycle shows memAddr=0, busy=0, next=0; ticks are ignored until start.
6. Edge cases:
   - beats_per_word=0 with base=0xFFFE, end=0x0001, wrap -> address advances every tick: FFFE, FFFF, 0000, 0001, FFFE.
   - start coincident with a tick -> memAddr=base and count=0.
